// File: rtl/ms_delay_scheduler_pkg.sv
// Shared definitions for ms_delay_scheduler: FSM state encoding, default sizes
// and the round-robin pointer step. Optional feature macro: DLY_CANCEL_EN.
package ms_delay_scheduler_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ms_delay_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins,
// returned both as a one-hot grant and as a binary index.
module rr_arbiter
    import ms_delay_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        int   cand;
        logic found;
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                index     = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ms_delay_scheduler.sv
// Shares one millisecond countdown among N_REQ requesters with round-robin arbitration.
// Define DLY_CANCEL_EN to add a cancel input that aborts the active countdown.
module ms_delay_scheduler
    import ms_delay_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick_src,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   req_dly,
`ifdef DLY_CANCEL_EN
    input  logic                     cancel,
`endif
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [CNT_W-1:0]         remaining
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    logic             tick_q;
    logic             tick_rise;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_next;
    logic [IDX_W-1:0] arb_index;
    logic [N_REQ-1:0] arb_gnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] owner_dly;
    logic             cancel_hit;
    logic             abort;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .index (arb_index)
    );

`ifdef DLY_CANCEL_EN
    assign cancel_hit = cancel;
`else
    assign cancel_hit = 1'b0;
`endif

    // tick_src is already in the clk domain, so a single register gives the edge.
    assign tick_rise  = tick_src & ~tick_q;
    assign abort      = ~req[owner] | cancel_hit;
    assign owner_dly  = req_dly[int'(owner)*CNT_W +: CNT_W];
    assign owner_next = IDX_W'(next_index(int'(owner), N_REQ));
    assign remaining  = cnt;

    // Abort is tested before the tick so a withdrawal beats a coinciding final tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tick_q <= 1'b0;
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
        end else begin
            tick_q <= tick_src;
            done   <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= arb_index;
                        grant <= arb_gnt;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        ptr   <= owner_next;
                        state <= IDLE;
                    end else begin
                        cnt   <= owner_dly;
                        state <= (owner_dly == '0) ? DONE : COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        ptr   <= owner_next;
                        state <= IDLE;
                    end else if (tick_rise) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done[owner] <= 1'b1;
                    grant       <= '0;
                    busy        <= 1'b0;
                    ptr         <= owner_next;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
